ex2_feeder: RTL and testbench
=============================

EX2_FEEDER -- requirements
Module: ex2_feeder

Interface
REQ-001 Parameter N, default 8: samples per row; a power of two, at least 2.
REQ-002 Parameter XW, default 9: sample width in bits.
REQ-003 Port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port i_in_valid, input, 1 bit: upstream sample valid.
REQ-006 Port o_in_ready, output, 1 bit: feeder can accept a sample this cycle.
REQ-007 Port i_in_x, input, XW bits: upstream sample.
REQ-008 Port i_alpha, input, 2 bits: PTF scale, sampled with the first sample of a row.
REQ-009 Port i_inv_n, input, 8 bits: 1/C in Q0.8, sampled with the first sample of a row.
REQ-010 Port o_valid, output, 1 bit: one-cycle row-start pulse to the Ex2 unit.
REQ-011 Port o_x, output, XW bits: streamed sample.
REQ-012 Port o_alpha, output, 2 bits: alpha of the row currently streaming.
REQ-013 Port o_inv_n, output, 8 bits: inv_n of the row currently streaming.
REQ-014 Port i_done, input, 1 bit: Ex2 unit done pulse.
REQ-015 Port o_busy, output, 1 bit: high when any bank is full or the stream FSM is not IDLE.

Function
REQ-016 The feeder SHALL hold two row banks (bank 0 and bank 1); each bank holds N samples plus an alpha/inv_n pair and a full flag.
REQ-017 A sample is accepted when i_in_valid and o_in_ready are both high; o_in_ready = NOT full[wr_bank].
REQ-018 Accepted samples SHALL be written to wr_bank at index wr_idx, then wr_idx increments.
REQ-019 When wr_idx is 0, alpha and inv_n are latched into wr_bank.
REQ-020 When wr_idx reaches N-1 and a sample is accepted: full[wr_bank] is set, wr_idx wraps to 0, and wr_bank toggles.
REQ-021 Stream FSM states and transitions: IDLE -> LAUNCH when full[rd_bank]; LAUNCH -> STREAM (always); STREAM -> WAIT after cnt = N-1; WAIT -> IDLE on i_done.
REQ-022 o_valid SHALL be high only in LAUNCH, for exactly one cycle.
REQ-023 In STREAM cycle k (k = 0..N-1, cnt starts at 0), o_x SHALL equal sample k of rd_bank; this is the cycle T+1+k where T is the o_valid cycle.
REQ-024 o_x SHALL be 0 outside STREAM.
REQ-025 o_alpha and o_inv_n SHALL hold rd_bank values from LAUNCH until IDLE, and be 0 otherwise.
REQ-026 On the WAIT->IDLE transition, full[rd_bank] is cleared and rd_bank toggles.
REQ-027 Acceptance and stream progress are independent: upstream may fill one bank while the other streams.
REQ-028 Simultaneous set (fill) and clear (release) SHALL hit different banks by construction, and both take effect.
REQ-029 i_done outside WAIT SHALL be ignored.
REQ-030 No timeout: WAIT persists until i_done.
REQ-031 Minimum row-to-row spacing is N+3 cycles: LAUNCH + N cycles of STREAM + at least 1 WAIT + 1 IDLE.
REQ-032 Changes to i_alpha or i_inv_n mid-row SHALL NOT affect the latched row values.

Reset
REQ-033 While i_rst is high, all outputs SHALL be 0, except o_in_ready, which is 1.
REQ-034 While i_rst is high: FSM = IDLE; wr_bank = rd_bank = 0; wr_idx = cnt = 0; both full flags = 0.
REQ-035 Bank sample storage need not be reset.
REQ-036 Reset mid-row SHALL discard partial and full rows; no o_valid is issued after reset until N new samples are accepted.

Structure
REQ-037 The shared LayerNorm package SHALL hold the N and XW defaults and the FSM state encodings (IDLE=0, LAUNCH=1, STREAM=2, WAIT=3).
REQ-038 One sub-module, ex2_row_bank (single bank: storage, config latch, full flag), SHALL be instantiated twice.

Verification
REQ-039 Single row: accept x = 1..8 with alpha = 1 and inv_n = 32 -> one o_valid pulse, o_x = 1..8 on the next 8 cycles, o_alpha = 1, o_inv_n = 32, o_busy low after i_done.
REQ-040 Back-to-back: 16 samples with i_in_valid held high -> o_in_ready never drops; second o_valid occurs 1 cycle after the first row's i_done is followed by IDLE.
REQ-041 Backpressure: 24 samples offered with i_done withheld -> o_in_ready low after sample 16; samples 17-24 are accepted only after the first i_done.
REQ-042 Config isolation: alpha toggles 2 -> 0 at sample 4 of row 0 -> o_alpha = 2 for row 0 and 0 for row 1.
REQ-043 Reset mid-stream: i_rst asserted in STREAM cycle k = 3 -> o_x = 0 and o_valid = 0 immediately; only 1 o_valid for a subsequent fresh 8-sample row.
REQ-044 Spurious i_done: i_done pulsed in IDLE and in STREAM -> no state, bank, or output change.

Source files
------------

// File: rtl/ex2_feeder_pkg.sv
// Shared LayerNorm definitions: default row geometry, Ex2 feeder FSM encoding
// and the per-row configuration payload.
package ex2_feeder_pkg;

    localparam int unsigned N_DEFAULT  = 8;
    localparam int unsigned XW_DEFAULT = 9;
    localparam int unsigned ALPHA_W    = 2;
    localparam int unsigned INV_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_STREAM = 2'd2,
        ST_WAIT   = 2'd3
    } feed_state_e;

    // Per-row scale pair latched with the first sample of a row
    typedef struct packed {
        logic [ALPHA_W-1:0] alpha;
        logic [INV_W-1:0]   inv_n;
    } row_cfg_t;

endpackage

// File: rtl/ex2_feeder_if.sv
// Feeder bus: upstream sample handshake plus the row stream towards the Ex2 unit.
interface ex2_feeder_if #(
    parameter int unsigned XW = ex2_feeder_pkg::XW_DEFAULT
) ();
    import ex2_feeder_pkg::*;

    logic               i_in_valid;
    logic               o_in_ready;
    logic [XW-1:0]      i_in_x;
    logic [ALPHA_W-1:0] i_alpha;
    logic [INV_W-1:0]   i_inv_n;
    logic               o_valid;
    logic [XW-1:0]      o_x;
    logic [ALPHA_W-1:0] o_alpha;
    logic [INV_W-1:0]   o_inv_n;
    logic               i_done;
    logic               o_busy;

    // Feeder side
    modport slave (
        input  i_in_valid, i_in_x, i_alpha, i_inv_n, i_done,
        output o_in_ready, o_valid, o_x, o_alpha, o_inv_n, o_busy
    );

    // Upstream / Ex2 side
    modport master (
        output i_in_valid, i_in_x, i_alpha, i_inv_n, i_done,
        input  o_in_ready, o_valid, o_x, o_alpha, o_inv_n, o_busy
    );

endinterface

// File: rtl/ex2_row_bank.sv
// One row bank: N-sample storage, row config latch and the full flag.
module ex2_row_bank
    import ex2_feeder_pkg::*;
#(
    parameter int unsigned N  = N_DEFAULT,
    parameter int unsigned XW = XW_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [$clog2(N)-1:0] i_wr_idx,
    input  logic [XW-1:0]        i_wr_x,
    input  row_cfg_t             i_cfg,
    input  logic                 i_clr,
    input  logic [$clog2(N)-1:0] i_rd_idx,
    output logic [XW-1:0]        o_rd_x,
    output row_cfg_t             o_cfg,
    output logic                 o_full
);

    localparam int unsigned IW = $clog2(N);

    logic [XW-1:0] mem [N];

    // Sample storage carries no reset; a row is only read once full
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_idx] <= i_wr_x;
        end
    end

    assign o_rd_x = mem[i_rd_idx];

    // Fill and release never target the same bank in the same cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cfg  <= '0;
            o_full <= 1'b0;
        end else begin
            if (i_wr_en && (i_wr_idx == IW'(0))) begin
                o_cfg <= i_cfg;
            end
            if (i_wr_en && (i_wr_idx == IW'(N - 1))) begin
                o_full <= 1'b1;
            end else if (i_clr) begin
                o_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex2_feeder.sv
// Double-buffered row feeder: fills one bank from upstream while the other
// bank is launched and streamed to the Ex2 unit.
module ex2_feeder
    import ex2_feeder_pkg::*;
#(
    parameter int unsigned N  = N_DEFAULT,
    parameter int unsigned XW = XW_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ex2_feeder_if.slave  bus
);

    localparam int unsigned IW = $clog2(N);

    feed_state_e   state;
    logic          wr_bank;
    logic          rd_bank;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] cnt;
    logic [1:0]    full;
    logic [XW-1:0] bank_x   [2];
    row_cfg_t      bank_cfg [2];
    row_cfg_t      in_cfg;
    logic          wr_fire;
    logic          release_row;

    assign in_cfg      = '{alpha: bus.i_alpha, inv_n: bus.i_inv_n};
    assign wr_fire     = bus.i_in_valid && !full[wr_bank];
    assign release_row = (state == ST_WAIT) && bus.i_done;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ex2_row_bank #(
            .N  (N),
            .XW (XW)
        ) u_bank (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_wr_en  (wr_fire && (wr_bank == 1'(b))),
            .i_wr_idx (wr_idx),
            .i_wr_x   (bus.i_in_x),
            .i_cfg    (in_cfg),
            .i_clr    (release_row && (rd_bank == 1'(b))),
            .i_rd_idx (cnt),
            .o_rd_x   (bank_x[b]),
            .o_cfg    (bank_cfg[b]),
            .o_full   (full[b])
        );
    end

    // Write pointer: advance per accepted sample, hop banks at row end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (wr_fire) begin
            if (wr_idx == IW'(N - 1)) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_idx <= wr_idx + IW'(1);
            end
        end
    end

    // Stream FSM; i_done only matters in WAIT, which has no timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            rd_bank <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (full[rd_bank]) begin
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (cnt == IW'(N - 1)) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus.i_done) begin
                        rd_bank <= ~rd_bank;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of flopped state and bank contents
    assign bus.o_in_ready = !full[wr_bank];
    assign bus.o_valid    = (state == ST_LAUNCH);
    assign bus.o_x        = (state == ST_STREAM) ? bank_x[rd_bank] : '0;
    assign bus.o_alpha    = (state != ST_IDLE) ? bank_cfg[rd_bank].alpha : '0;
    assign bus.o_inv_n    = (state != ST_IDLE) ? bank_cfg[rd_bank].inv_n : '0;
    assign bus.o_busy     = (|full) || (state != ST_IDLE);

endmodule

// File: tb/tb_ex2_feeder.sv
// Directed bench for ex2_feeder: single row, back-to-back rows, backpressure,
// config isolation, reset mid-stream and spurious done pulses.
module tb_ex2_feeder;

    localparam int unsigned N  = 8;
    localparam int unsigned XW = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned vq[$];
    bit          stall = 1'b0;

    ex2_feeder_if #(.XW(XW)) bus ();

    ex2_feeder #(
        .N  (N),
        .XW (XW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record launch cycles and any refused offer
    always @(negedge clk) begin
        if (!rst && bus.o_valid) vq.push_back(cyc);
        if (!rst && bus.i_in_valid && !bus.o_in_ready) stall = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.i_in_valid = 1'b0;
        bus.i_done     = 1'b0;
        rst            = 1'b1;
        tick();
        check("rst_valid", bus.o_valid, 0);
        check("rst_x", bus.o_x, 0);
        check("rst_alpha", bus.o_alpha, 0);
        check("rst_inv", bus.o_inv_n, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_ready", bus.o_in_ready, 1);
        rst = 1'b0;
        tick();
        vq.delete();
        stall = 1'b0;
    endtask

    task automatic push(input int unsigned x, input int unsigned a, input int unsigned inv,
                        output int unsigned acc);
        bus.i_in_valid = 1'b1;
        bus.i_in_x     = XW'(x);
        bus.i_alpha    = 2'(a);
        bus.i_inv_n    = 8'(inv);
        for (int w = 0; w < 60 && !bus.o_in_ready; w++) tick();
        check("push_ready", bus.o_in_ready, 1);
        tick();
        acc = cyc;
    endtask

    task automatic wait_launch(output int unsigned t);
        for (int w = 0; w < 60 && !bus.o_valid; w++) tick();
        check("launch", bus.o_valid, 1);
        t = cyc;
    endtask

    task automatic wait_cyc(input int unsigned target);
        for (int w = 0; w < 60 && cyc < target; w++) tick();
        check("wait_cyc", cyc, target);
    endtask

    // Called at the LAUNCH cycle; ends in the first WAIT cycle
    task automatic stream_check(input int unsigned first, input int unsigned a,
                                input int unsigned inv, input int spur_k);
        check("l_x", bus.o_x, 0);
        check("l_alpha", bus.o_alpha, a);
        check("l_inv", bus.o_inv_n, inv);
        for (int k = 0; k < N; k++) begin
            tick();
            bus.i_done = 1'b0;
            check($sformatf("s_x%0d", k), bus.o_x, first + k);
            check($sformatf("s_valid%0d", k), bus.o_valid, 0);
            check($sformatf("s_alpha%0d", k), bus.o_alpha, a);
            check($sformatf("s_inv%0d", k), bus.o_inv_n, inv);
            if (k == spur_k) bus.i_done = 1'b1;
        end
        tick();
        bus.i_done = 1'b0;
        check("w_x", bus.o_x, 0);
        check("w_valid", bus.o_valid, 0);
        check("w_busy", bus.o_busy, 1);
        check("w_alpha", bus.o_alpha, a);
        check("w_inv", bus.o_inv_n, inv);
    endtask

    task automatic release_row(input int unsigned exp_busy);
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        check("rel_busy", bus.o_busy, exp_busy);
        check("rel_alpha", bus.o_alpha, 0);
        check("rel_inv", bus.o_inv_n, 0);
        check("rel_x", bus.o_x, 0);
    endtask

    int unsigned acc, acc_first, t0, t1, d;
    int unsigned acc_c [25];

    initial begin
        bus.i_in_valid = 1'b0;
        bus.i_in_x     = '0;
        bus.i_alpha    = '0;
        bus.i_inv_n    = '0;
        bus.i_done     = 1'b0;

        // Single row
        do_reset();
        for (int i = 1; i <= 8; i++) push(i, 1, 32, acc);
        bus.i_in_valid = 1'b0;
        wait_launch(t0);
        check("t1_lat", t0, acc + 1);
        stream_check(1, 1, 32, 99);
        release_row(0);
        check("t1_ready", bus.o_in_ready, 1);

        // Back-to-back rows with valid held high
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            push(i, 1, 32, acc);
            if (i == 1) acc_first = acc;
        end
        bus.i_in_valid = 1'b0;
        check("t2_span", acc - acc_first, 15);
        check("t2_stall", 32'(stall), 0);
        check("t2_nvalid", vq.size(), 1);
        t0 = (vq.size() > 0) ? vq[0] : 0;
        wait_cyc(t0 + N + 1);
        check("t2_wait_busy", bus.o_busy, 1);
        check("t2_wait_x", bus.o_x, 0);
        release_row(1);
        wait_launch(t1);
        check("t2_gap", t1, t0 + N + 3);
        stream_check(9, 1, 32, 99);
        release_row(0);

        // Backpressure: third row waits for the first release
        do_reset();
        d = 0;
        fork
            begin
                for (int i = 1; i <= 24; i++) push(i, 1, 32, acc_c[i]);
                bus.i_in_valid = 1'b0;
            end
            begin
                for (int w = 0; w < 60 && vq.size() == 0; w++) tick();
                t0 = (vq.size() > 0) ? vq[0] : 0;
                wait_cyc(t0 + N + 5);
                check("t3_ready_lo", bus.o_in_ready, 0);
                check("t3_busy", bus.o_busy, 1);
                bus.i_done = 1'b1;
                tick();
                bus.i_done = 1'b0;
                d = cyc;
            end
        join
        check("t3_first16", acc_c[16] - acc_c[1], 15);
        check("t3_resume", acc_c[17], d + 1);
        check("t3_last", acc_c[24], d + 8);
        check("t3_nvalid", vq.size(), 2);
        check("t3_launch2", (vq.size() > 1) ? vq[1] : 0, d + 1);

        // Config isolation
        do_reset();
        for (int i = 1; i <= 16; i++) push(i, (i < 4) ? 2 : 0, (i < 4) ? 32 : 77, acc);
        bus.i_in_valid = 1'b0;
        check("t4_alpha0", bus.o_alpha, 2);
        check("t4_inv0", bus.o_inv_n, 32);
        t0 = (vq.size() > 0) ? vq[0] : 0;
        wait_cyc(t0 + N + 1);
        release_row(1);
        wait_launch(t1);
        stream_check(9, 0, 77, 99);
        release_row(0);

        // Reset mid-stream with a partial second row pending
        do_reset();
        for (int i = 1; i <= 11; i++) push(i, 3, 200, acc);
        bus.i_in_valid = 1'b0;
        t0 = (vq.size() > 0) ? vq[0] : 0;
        wait_cyc(t0 + 4);
        check("t5_x3", bus.o_x, 4);
        rst = 1'b1;
        #1;
        check("t5_rst_x", bus.o_x, 0);
        check("t5_rst_valid", bus.o_valid, 0);
        check("t5_rst_alpha", bus.o_alpha, 0);
        check("t5_rst_ready", bus.o_in_ready, 1);
        do_reset();
        for (int i = 101; i <= 108; i++) push(i, 1, 5, acc);
        bus.i_in_valid = 1'b0;
        wait_launch(t1);
        check("t5_lat", t1, acc + 1);
        stream_check(101, 1, 5, 99);
        release_row(0);
        repeat (12) tick();
        check("t5_nvalid", vq.size(), 1);

        // Spurious done in IDLE and in STREAM
        do_reset();
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        tick();
        check("t6_idle_busy", bus.o_busy, 0);
        check("t6_idle_ready", bus.o_in_ready, 1);
        check("t6_idle_valid", bus.o_valid, 0);
        for (int i = 1; i <= 8; i++) push(20 + i, 2, 99, acc);
        bus.i_in_valid = 1'b0;
        wait_launch(t1);
        stream_check(21, 2, 99, 2);
        repeat (5) tick();
        check("t6_hold_busy", bus.o_busy, 1);
        check("t6_hold_alpha", bus.o_alpha, 2);
        check("t6_hold_valid", bus.o_valid, 0);
        release_row(0);
        check("t6_nvalid", vq.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
